// File: rtl/descrambler_lock_ctrl.sv
// -----------------------------------------------------------------------------
// descrambler_lock_ctrl
//
// Per-lane lock controller for the 256-bit (4x64b) self-synchronising
// descrambler in the 25G PCS receive path. It sequences the descrambler
// enable, waits for the descrambler state to fill, qualifies a run of clean
// words before declaring lock, and then monitors the error rate in fixed
// windows while locked. A high error rate or a software request forces a
// relock: the descrambler is disabled for a flush period and then re-seeded.
//
// Optional feature: define DESCR_LOCK_STATS_EN to add the saturating
// statistics outputs out_lock_loss_cnt and out_err_total.
//
// Ports:
//   clk                in   core clock
//   reset_n            in   synchronous active-low reset
//   in_txdata_valid    in   word-valid from the descrambler
//   in_txdata_error    in   word-error from the descrambler (qualified by valid)
//   in_idle            in   lane idle; freezes all word counters while high
//   in_force_relock    in   single-cycle software relock request
//   out_enable         out  enable to the descrambler
//   out_locked         out  lane locked (consumed by deskew/alignment)
//   out_hi_ber         out  high error rate flag, sticky until next lock
//   out_relock_pulse   out  one-cycle pulse on every entry to FLUSH
//   out_state          out  encoded FSM state
//                           (FLUSH=0 SEED=1 CHECK=2 LOCKED=3 HI_BER=4)
//   out_win_err        out  errored words in the current window, saturating
//   out_lock_loss_cnt  out  [DESCR_LOCK_STATS_EN] LOCKED exits to HI_BER/FLUSH
//   out_err_total      out  [DESCR_LOCK_STATS_EN] errored words outside FLUSH
// -----------------------------------------------------------------------------
module descrambler_lock_ctrl #(
  parameter int SEED_WORDS = 2,
  parameter int GOOD_WORDS = 8,
  parameter int WIN_LEN    = 64,
  parameter int BER_THRESH = 4,
  parameter int FLUSH_CYC  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_txdata_valid,
  input  logic       in_txdata_error,
  input  logic       in_idle,
  input  logic       in_force_relock,
  output logic       out_enable,
  output logic       out_locked,
  output logic       out_hi_ber,
  output logic       out_relock_pulse,
  output logic [2:0] out_state,
  output logic [7:0] out_win_err
`ifdef DESCR_LOCK_STATS_EN
  ,
  output logic [15:0] out_lock_loss_cnt,
  output logic [31:0] out_err_total
`endif
);

  // One word counter is shared by SEED (fill count), CHECK (good-run count)
  // and LOCKED (window position), so it is sized for the largest of the three.
  localparam int MAX_SG    = (SEED_WORDS > GOOD_WORDS) ? SEED_WORDS : GOOD_WORDS;
  localparam int MAX_WORDS = (MAX_SG > WIN_LEN) ? MAX_SG : WIN_LEN;
  localparam int WC_W      = $clog2(MAX_WORDS + 1);
  localparam int FC_W      = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_SEED   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_HI_BER = 3'd4
  } state_t;

  state_t          r_state;
  logic [FC_W-1:0] r_flush_cnt;
  logic [WC_W-1:0] r_word_cnt;
  logic [7:0]      r_win_err;
  logic            r_enable;
  logic            r_locked;
  logic            r_hi_ber;
  logic            r_relock_pulse;

  logic            w_word;
  logic            w_err_word;
  logic            w_force;
  logic            w_flush_done;
  logic            w_seed_last;
  logic            w_good_last;
  logic            w_win_last;
  logic            w_ber_trip;
  logic [7:0]      w_win_err_inc;

  // A word is a valid beat while the lane is not idle; idle beats and
  // errors on invalid beats never touch the word counters.
  assign w_word     = in_txdata_valid & ~in_idle;
  assign w_err_word = w_word & in_txdata_error;

  // A relock request in FLUSH only restarts the flush timer, so it is not
  // treated as a fresh entry (no pulse).
  assign w_force = in_force_relock & (r_state != ST_FLUSH);

  assign w_flush_done = (r_flush_cnt == FC_W'(FLUSH_CYC - 1));
  assign w_seed_last  = (r_word_cnt == WC_W'(SEED_WORDS - 1));
  assign w_good_last  = (r_word_cnt == WC_W'(GOOD_WORDS - 1));
  assign w_win_last   = (r_word_cnt == WC_W'(WIN_LEN - 1));

  assign w_win_err_inc = (r_win_err == 8'hFF) ? r_win_err : (r_win_err + 8'd1);

  // The current word's error is added to the running window count before
  // the threshold compare, so the trip happens on the offending word itself,
  // even when that word also closes the window.
  assign w_ber_trip = (r_state == ST_LOCKED) & w_err_word &
                      (({1'b0, r_win_err} + 9'd1) >= 9'(BER_THRESH));

  // Main lock FSM. All outputs are registered here so that each one changes
  // exactly one clock after the input edge that caused it. A forced relock is
  // checked first because it overrides every other transition, including the
  // BER trip in LOCKED and the one-cycle HI_BER exit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_FLUSH;
      r_flush_cnt    <= '0;
      r_word_cnt     <= '0;
      r_win_err      <= '0;
      r_enable       <= 1'b0;
      r_locked       <= 1'b0;
      r_hi_ber       <= 1'b0;
      r_relock_pulse <= 1'b0;
    end else begin
      r_relock_pulse <= 1'b0;
      if (w_force) begin
        r_state        <= ST_FLUSH;
        r_flush_cnt    <= '0;
        r_word_cnt     <= '0;
        r_win_err      <= '0;
        r_enable       <= 1'b0;
        r_locked       <= 1'b0;
        r_relock_pulse <= 1'b1;
      end else begin
        case (r_state)
          ST_FLUSH: begin
            // The flush timer runs on clock cycles, not words, so it keeps
            // counting through idle.
            if (in_force_relock) begin
              r_flush_cnt <= '0;
            end else if (w_flush_done) begin
              r_state     <= ST_SEED;
              r_enable    <= 1'b1;
              r_flush_cnt <= '0;
              r_word_cnt  <= '0;
            end else begin
              r_flush_cnt <= r_flush_cnt + FC_W'(1);
            end
          end

          ST_SEED: begin
            // Errors are meaningless while the descrambler state fills.
            if (w_word) begin
              if (w_seed_last) begin
                r_state    <= ST_CHECK;
                r_word_cnt <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + WC_W'(1);
              end
            end
          end

          ST_CHECK: begin
            // Needs an unbroken run of clean words; any error restarts the
            // run and there is deliberately no timeout out of this state.
            if (w_word) begin
              if (in_txdata_error) begin
                r_word_cnt <= '0;
              end else if (w_good_last) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_hi_ber   <= 1'b0;
                r_word_cnt <= '0;
                r_win_err  <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + WC_W'(1);
              end
            end
          end

          ST_LOCKED: begin
            // r_word_cnt is the position in the monitoring window here.
            if (w_word) begin
              if (w_ber_trip) begin
                r_state   <= ST_HI_BER;
                r_locked  <= 1'b0;
                r_hi_ber  <= 1'b1;
                r_win_err <= w_win_err_inc;
              end else if (w_win_last) begin
                r_word_cnt <= '0;
                r_win_err  <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + WC_W'(1);
                if (in_txdata_error) begin
                  r_win_err <= w_win_err_inc;
                end
              end
            end
          end

          ST_HI_BER: begin
            // Single-cycle notification state; out_hi_ber stays set until
            // the lane locks again.
            r_state        <= ST_FLUSH;
            r_flush_cnt    <= '0;
            r_word_cnt     <= '0;
            r_win_err      <= '0;
            r_enable       <= 1'b0;
            r_locked       <= 1'b0;
            r_relock_pulse <= 1'b1;
          end

          default: begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
            r_word_cnt  <= '0;
            r_win_err   <= '0;
            r_enable    <= 1'b0;
            r_locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_enable       = r_enable;
  assign out_locked       = r_locked;
  assign out_hi_ber       = r_hi_ber;
  assign out_relock_pulse = r_relock_pulse;
  assign out_state        = r_state;
  assign out_win_err      = r_win_err;

`ifdef DESCR_LOCK_STATS_EN
  logic [15:0] r_lock_loss_cnt;
  logic [31:0] r_err_total;
  logic        w_lock_loss;
  logic        w_err_count;

  // Any exit from LOCKED is either a BER trip or a forced relock.
  assign w_lock_loss = (r_state == ST_LOCKED) & (in_force_relock | w_ber_trip);
  assign w_err_count = w_err_word & (r_state != ST_FLUSH);

  // Statistics counters saturate rather than wrap so software never sees a
  // small value after a long error storm; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock_loss_cnt <= '0;
      r_err_total     <= '0;
    end else begin
      if (w_lock_loss && (r_lock_loss_cnt != 16'hFFFF)) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
      end
      if (w_err_count && (r_err_total != 32'hFFFF_FFFF)) begin
        r_err_total <= r_err_total + 32'd1;
      end
    end
  end

  assign out_lock_loss_cnt = r_lock_loss_cnt;
  assign out_err_total     = r_err_total;
`endif

endmodule

// File: tb/tb_descrambler_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_descrambler_lock_ctrl
//
// Scoreboard bench for descrambler_lock_ctrl. Stimulus is driven on the
// falling edge; the expected outputs for the following rising edge are pushed
// into a queue at the same time and a monitor pops and compares them shortly
// after that rising edge. Fields set to -1 in an expectation are not checked.
// -----------------------------------------------------------------------------
module tb_descrambler_lock_ctrl;

  localparam int FLUSH = 0;
  localparam int SEED = 1;
  localparam int CHECK = 2;
  localparam int LOCKED = 3;
  localparam int HI_BER = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       inValid = 1'b0;
  logic       inErr = 1'b0;
  logic       inIdle = 1'b0;
  logic       inForce = 1'b0;
  logic       outEnable;
  logic       outLocked;
  logic       outHiBer;
  logic       outPulse;
  logic [2:0] outState;
  logic [7:0] outWinErr;
`ifdef DESCR_LOCK_STATS_EN
  logic [15:0] outLockLoss;
  logic [31:0] outErrTotal;
`endif

  typedef struct {
    string tag;
    int    at;
    int    st;
    int    en;
    int    lk;
    int    hb;
    int    pl;
    int    we;
    int    llc;
    int    etot;
  } expT;

  expT expQ[$];
  int  cycleNo = 0;
  int  compared = 0;
  int  mismatched = 0;

  descrambler_lock_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_txdata_valid  (inValid),
    .in_txdata_error  (inErr),
    .in_idle          (inIdle),
    .in_force_relock  (inForce),
    .out_enable       (outEnable),
    .out_locked       (outLocked),
    .out_hi_ber       (outHiBer),
    .out_relock_pulse (outPulse),
    .out_state        (outState),
    .out_win_err      (outWinErr)
`ifdef DESCR_LOCK_STATS_EN
    ,
    .out_lock_loss_cnt(outLockLoss),
    .out_err_total    (outErrTotal)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge.
  task automatic applyStimulus(input logic rn, input logic v, input logic e,
                               input logic idl, input logic frc);
    @(negedge clk);
    reset_n = rn;
    inValid = v;
    inErr   = e;
    inIdle  = idl;
    inForce = frc;
  endtask

  // Expected outputs after the next rising edge.
  function automatic void expectNext(input string tag, input int st, input int en,
                                     input int lk, input int hb, input int pl,
                                     input int we);
    expT x;
    x.tag = tag; x.at = cycleNo + 1;
    x.st = st; x.en = en; x.lk = lk; x.hb = hb; x.pl = pl; x.we = we;
    x.llc = -1; x.etot = -1;
    expQ.push_back(x);
  endfunction

  function automatic void expectStats(input string tag, input int llc, input int etot);
    expT x;
    x.tag = tag; x.at = cycleNo + 1;
    x.st = -1; x.en = -1; x.lk = -1; x.hb = -1; x.pl = -1; x.we = -1;
    x.llc = llc; x.etot = etot;
    expQ.push_back(x);
  endfunction

  // Monitor: pops every expectation due at this edge and compares it.
  always @(posedge clk) begin : monitor
    expT x;
    cycleNo++;
    #1;
    while (expQ.size() > 0 && expQ[0].at <= cycleNo) begin
      x = expQ.pop_front();
      if (x.st >= 0) checkOutput({x.tag, ".state"}, int'(outState), x.st);
      if (x.en >= 0) checkOutput({x.tag, ".enable"}, int'(outEnable), x.en);
      if (x.lk >= 0) checkOutput({x.tag, ".locked"}, int'(outLocked), x.lk);
      if (x.hb >= 0) checkOutput({x.tag, ".hi_ber"}, int'(outHiBer), x.hb);
      if (x.pl >= 0) checkOutput({x.tag, ".pulse"}, int'(outPulse), x.pl);
      if (x.we >= 0) checkOutput({x.tag, ".win_err"}, int'(outWinErr), x.we);
`ifdef DESCR_LOCK_STATS_EN
      if (x.llc >= 0) checkOutput({x.tag, ".lock_loss"}, int'(outLockLoss), x.llc);
      if (x.etot >= 0) checkOutput({x.tag, ".err_total"}, int'(outErrTotal), x.etot);
`endif
    end
  end

  // From a freshly entered FLUSH (reset or forced): 16 flush cycles, then
  // 2 seed words, then 8 clean words to lock. Valid every cycle, no errors.
  task automatic runLockSequence(input string tag);
    int st;
    for (int i = 1; i <= 26; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      st = (i < 16) ? FLUSH : (i < 18) ? SEED : (i < 26) ? CHECK : LOCKED;
      expectNext($sformatf("%s%0d", tag, i), st, (i < 16) ? 0 : 1,
                 (i == 26) ? 1 : 0, 0, 0, 0);
    end
  endtask

  initial begin
    int errs;
    $display("[TB] start");

    // Reset with busy inputs: everything cleared, state FLUSH, no pulse.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    expectNext("rst", FLUSH, 0, 0, 0, 0, 0);
    expectStats("rstStats", 0, 0);

    // Lock from reset.
    runLockSequence("lock");
    expectStats("lockStats", 0, 0);

    // Five windows with 3 errors each: stay locked, window count wraps to 0.
    for (int w = 0; w < 5; w++) begin
      for (int j = 1; j <= 64; j++) begin
        applyStimulus(1'b1, 1'b1, (j == 10 || j == 20 || j == 30), 1'b0, 1'b0);
        errs = int'(j >= 10) + int'(j >= 20) + int'(j >= 30);
        expectNext($sformatf("win%0d_%0d", w, j), LOCKED, 1, 1, 0, 0,
                   (j == 64) ? 0 : errs);
      end
    end
    // Errors on invalid or idle beats are not words.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, (k >= 2), 1'b1, (k >= 2), 1'b0);
      expectNext($sformatf("nonword%0d", k), LOCKED, 1, 1, 0, 0, 0);
    end
    expectStats("winStats", 0, 15);

    // Fourth error lands on the window-closing word: trips HI_BER anyway.
    for (int j = 1; j <= 64; j++) begin
      applyStimulus(1'b1, 1'b1, (j <= 3 || j == 64), 1'b0, 1'b0);
      if (j < 64)
        expectNext($sformatf("ber%0d", j), LOCKED, 1, 1, 0, 0, (j < 3) ? j : 3);
      else
        expectNext("ber64", HI_BER, -1, 0, 1, 0, -1);
    end
    expectStats("berStats", 1, 19);
    // FLUSH for 16 cycles with enable low; pulse only on the first.
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expectNext($sformatf("bflush%0d", k), (k == 16) ? SEED : FLUSH,
                 (k == 16) ? 1 : 0, 0, 1, (k == 0) ? 1 : 0, 0);
    end

    // Idle with valid in SEED: no progress.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      expectNext($sformatf("idleSeed%0d", k), SEED, 1, 0, 1, 0, 0);
    end
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expectNext($sformatf("seed%0d", k), (k == 2) ? CHECK : SEED, 1, 0, 1, 0, 0);
    end
    // Error on the 5th good word: lock on the 13th word; hi_ber clears then.
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b1, 1'b1, (k == 5), 1'b0, 1'b0);
      expectNext($sformatf("chk%0d", k), (k == 13) ? LOCKED : CHECK, 1,
                 (k == 13) ? 1 : 0, (k == 13) ? 0 : 1, 0, 0);
    end
    expectStats("chkStats", 1, 20);

    // Three errors, then force relock with a simultaneous error: FLUSH, no HI_BER.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      expectNext($sformatf("preForce%0d", k), LOCKED, 1, 1, 0, 0, k);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expectNext("force", FLUSH, 0, 0, 0, 1, 0);
    expectStats("forceStats", 2, 24);

    // Force relock inside FLUSH restarts the flush timer without a pulse.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, (k == 5));
      expectNext($sformatf("fl%0d", k), FLUSH, 0, 0, 0, 0, 0);
    end
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expectNext($sformatf("restart%0d", k), (k == 16) ? SEED : FLUSH,
                 (k == 16) ? 1 : 0, 0, 0, 0, 0);
    end
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expectNext($sformatf("relock%0d", k),
                 (k == 1) ? SEED : (k < 10) ? CHECK : LOCKED, 1,
                 (k == 10) ? 1 : 0, 0, 0, 0);
    end

    // Mid-operation reset clears everything, including statistics.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expectNext("midRst", FLUSH, 0, 0, 0, 0, 0);
    expectStats("midRstStats", 0, 0);
    runLockSequence("rlock");

    // Three forced relocks from LOCKED.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      expectNext($sformatf("frc%0d", r), FLUSH, 0, 0, 0, 1, 0);
      runLockSequence($sformatf("frc%0d_", r));
    end
    expectStats("lossStats", 3, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("drain", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
